// File: rtl/reset_io_ctrl.sv
// Reset sequencer and pad interface: stretches core reset, takes a soft reset, synchronises inputs, gates outputs.
// Latency: outputs registered one cycle; pin_in SYNC_STAGES cycles; edge pulses one cycle after pin_in. No backpressure.
module reset_io_ctrl #(
    parameter int PINS        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int RST_HOLD    = 16
) (
    input  logic            clk_cog,
    input  logic            nres,
    input  logic            sw_res,
    input  logic [PINS-1:0] pin_in_raw,
    input  logic [PINS-1:0] pin_out_core,
    input  logic [PINS-1:0] pin_dir_core,
    output logic            core_nres,
    output logic [PINS-1:0] pin_in,
    output logic [PINS-1:0] pin_out,
    output logic [PINS-1:0] pin_dir,
    output logic [PINS-1:0] pin_rise,
    output logic [PINS-1:0] pin_fall,
    output logic [1:0]      rst_state
);

    localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RST_HOLD - 1);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]                      state;
    logic [1:0]                      next_state;
    logic [CW-1:0]                   cnt;
    logic [CW-1:0]                   next_cnt;
    logic [SYNC_STAGES-1:0][PINS-1:0] sync_q;
    logic [PINS-1:0]                 prev_q;
    logic                            run_next;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_RESET: begin
                next_state = ST_HOLD;
                next_cnt   = '0;
            end
            ST_HOLD: begin
                if (sw_res) begin
                    next_cnt = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = ST_RUN;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (sw_res) begin
                    next_state = ST_HOLD;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = ST_RESET;
                next_cnt   = '0;
            end
        endcase
    end

    assign run_next  = (next_state == ST_RUN);
    assign pin_in    = sync_q[SYNC_STAGES-1];
    assign rst_state = state;

    // nres low wins over everything; the RESET state itself only lasts while nres is held low
    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            state     <= ST_RESET;
            cnt       <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
            core_nres <= 1'b0;
            pin_out   <= '0;
            pin_dir   <= '0;
            pin_rise  <= '0;
            pin_fall  <= '0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            sync_q[0] <= pin_in_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q    <= pin_in;
            core_nres <= run_next;
            pin_out   <= run_next ? pin_out_core : '0;
            pin_dir   <= run_next ? pin_dir_core : '0;
            // edges seen outside RUN are dropped so the core never sees stale events
            pin_rise  <= (state == ST_RUN) ? (pin_in & ~prev_q) : '0;
            pin_fall  <= (state == ST_RUN) ? (~pin_in & prev_q) : '0;
        end
    end

endmodule

// File: tb/tb_reset_io_ctrl.sv
// Scoreboard bench for reset_io_ctrl: stimulus queues expected values per edge, a negedge monitor checks them.
module tb_reset_io_ctrl;

    logic clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    int cyc = 0;
    always @(posedge clk_cog) cyc <= cyc + 1;

    // main instance: 32 pins, 3-stage synchroniser, 16-cycle hold
    logic        nres, sw_res;
    logic [31:0] raw, oc, dc;
    logic        core_nres;
    logic [31:0] pin_in, pin_out, pin_dir, pin_rise, pin_fall;
    logic [1:0]  rst_state;

    // wide instance: 64 pins, 1-stage synchroniser, 1-cycle hold
    logic        nres1, sw1;
    logic [63:0] raw1, oc1, dc1;
    logic        core_nres1;
    logic [63:0] pin_in1, pin_out1, pin_dir1, pin_rise1, pin_fall1;
    logic [1:0]  rst_state1;

    // narrow instance: 1 pin, 2-stage synchroniser, 1-cycle hold
    logic        raw2, oc2, dc2;
    logic        core_nres2, pin_in2, pin_out2, pin_dir2, pin_rise2, pin_fall2;
    logic [1:0]  rst_state2;

    reset_io_ctrl #(.PINS(32), .SYNC_STAGES(3), .RST_HOLD(16)) d0 (
        .clk_cog(clk_cog), .nres(nres), .sw_res(sw_res), .pin_in_raw(raw),
        .pin_out_core(oc), .pin_dir_core(dc), .core_nres(core_nres), .pin_in(pin_in),
        .pin_out(pin_out), .pin_dir(pin_dir), .pin_rise(pin_rise), .pin_fall(pin_fall),
        .rst_state(rst_state));

    reset_io_ctrl #(.PINS(64), .SYNC_STAGES(1), .RST_HOLD(1)) d1 (
        .clk_cog(clk_cog), .nres(nres1), .sw_res(sw1), .pin_in_raw(raw1),
        .pin_out_core(oc1), .pin_dir_core(dc1), .core_nres(core_nres1), .pin_in(pin_in1),
        .pin_out(pin_out1), .pin_dir(pin_dir1), .pin_rise(pin_rise1), .pin_fall(pin_fall1),
        .rst_state(rst_state1));

    reset_io_ctrl #(.PINS(1), .SYNC_STAGES(2), .RST_HOLD(1)) d2 (
        .clk_cog(clk_cog), .nres(nres1), .sw_res(sw1), .pin_in_raw(raw2),
        .pin_out_core(oc2), .pin_dir_core(dc2), .core_nres(core_nres2), .pin_in(pin_in2),
        .pin_out(pin_out2), .pin_dir(pin_dir2), .pin_rise(pin_rise2), .pin_fall(pin_fall2),
        .rst_state(rst_state2));

    localparam int S_NRES = 0, S_STATE = 1, S_IN = 2, S_OUT = 3, S_DIR = 4, S_RISE = 5, S_FALL = 6;
    localparam int S_NRES1 = 10, S_STATE1 = 11, S_IN1 = 12, S_DIR1 = 13, S_RISE1 = 14;
    localparam int S_NRES2 = 20, S_DIR2 = 21, S_IN2 = 22;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic expect_at(input int c, input int s, input logic [63:0] v);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    // drive inputs in the cycle before edge k so edge k samples them
    task automatic at(input int k);
        while (cyc < k - 1) @(negedge clk_cog);
    endtask

    function automatic logic [63:0] actual(input int s);
        case (s)
            S_NRES:   return 64'(core_nres);
            S_STATE:  return 64'(rst_state);
            S_IN:     return 64'(pin_in);
            S_OUT:    return 64'(pin_out);
            S_DIR:    return 64'(pin_dir);
            S_RISE:   return 64'(pin_rise);
            S_FALL:   return 64'(pin_fall);
            S_NRES1:  return 64'(core_nres1);
            S_STATE1: return 64'(rst_state1);
            S_IN1:    return pin_in1;
            S_DIR1:   return pin_dir1;
            S_RISE1:  return pin_rise1;
            S_NRES2:  return 64'(core_nres2);
            S_DIR2:   return 64'(pin_dir2);
            S_IN2:    return 64'(pin_in2);
            default:  return 64'hxxxx_xxxx_xxxx_xxxx;
        endcase
    endfunction

    function automatic string sel_name(input int s);
        case (s)
            S_NRES:   return "core_nres";
            S_STATE:  return "rst_state";
            S_IN:     return "pin_in";
            S_OUT:    return "pin_out";
            S_DIR:    return "pin_dir";
            S_RISE:   return "pin_rise";
            S_FALL:   return "pin_fall";
            S_NRES1:  return "core_nres_p64";
            S_STATE1: return "rst_state_p64";
            S_IN1:    return "pin_in_p64";
            S_DIR1:   return "pin_dir_p64";
            S_RISE1:  return "pin_rise_p64";
            S_NRES2:  return "core_nres_p1";
            S_DIR2:   return "pin_dir_p1";
            S_IN2:    return "pin_in_p1";
            default:  return "unknown";
        endcase
    endfunction

    always @(negedge clk_cog) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [63:0] a;
                a = actual(sb[i].sel);
                tests++;
                if (sb[i].cyc < cyc || a !== sb[i].val) begin
                    fails++;
                    $display("FAIL %s after edge %0d: got %h, want %h",
                             sel_name(sb[i].sel), sb[i].cyc, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        nres = 1'b0; sw_res = 1'b0; raw = '0; oc = 32'hA5A5_A5A5; dc = 32'hFFFF_FFFF;
        nres1 = 1'b0; sw1 = 1'b0; raw1 = '0; oc1 = 64'hDEAD_BEEF_0123_4567; dc1 = '1;
        raw2 = 1'b0; oc2 = 1'b1; dc2 = 1'b1;

        expect_at(3, S_NRES, 0);   expect_at(3, S_STATE, 0); expect_at(3, S_DIR, 0);
        expect_at(3, S_OUT, 0);    expect_at(3, S_RISE, 0);
        expect_at(5, S_NRES1, 0);  expect_at(5, S_STATE1, 0); expect_at(5, S_DIR1, 0);

        at(10); nres = 1'b1; nres1 = 1'b1;
        expect_at(10, S_STATE, 1);  expect_at(10, S_NRES, 0);
        expect_at(25, S_NRES, 0);   expect_at(25, S_STATE, 1); expect_at(25, S_DIR, 0);
        expect_at(26, S_NRES, 1);   expect_at(26, S_STATE, 2);
        expect_at(26, S_DIR, 64'hFFFF_FFFF); expect_at(26, S_OUT, 64'hA5A5_A5A5);
        expect_at(10, S_STATE1, 1); expect_at(10, S_NRES1, 0);
        expect_at(11, S_NRES1, 1);  expect_at(11, S_STATE1, 2); expect_at(11, S_DIR1, '1);
        expect_at(10, S_NRES2, 0);  expect_at(11, S_NRES2, 1);  expect_at(11, S_DIR2, 1);

        at(12); raw[0] = 1'b1;
        expect_at(14, S_IN, 1); expect_at(15, S_RISE, 0); expect_at(16, S_RISE, 0);

        at(18); raw[0] = 1'b0;
        expect_at(20, S_IN, 0); expect_at(21, S_FALL, 0);

        at(20); raw1[63] = 1'b1; raw2 = 1'b1;
        expect_at(20, S_IN1, 64'h8000_0000_0000_0000);
        expect_at(21, S_RISE1, 64'h8000_0000_0000_0000);
        expect_at(22, S_RISE1, 0);
        expect_at(20, S_IN2, 0); expect_at(21, S_IN2, 1);

        at(30); raw[0] = 1'b1;
        expect_at(32, S_IN, 1);   expect_at(33, S_RISE, 1);
        expect_at(34, S_RISE, 0); expect_at(34, S_FALL, 0);
        expect_at(35, S_OUT, 64'hA5A5_A5A5);

        at(36); oc = 32'h1234_5678;
        expect_at(36, S_OUT, 64'h1234_5678);
        expect_at(39, S_NRES, 1);

        at(40); sw_res = 1'b1;
        expect_at(40, S_NRES, 0); expect_at(40, S_DIR, 0);
        expect_at(40, S_STATE, 1); expect_at(40, S_OUT, 0);

        at(41); sw_res = 1'b0;
        expect_at(55, S_NRES, 0); expect_at(56, S_NRES, 1);
        expect_at(56, S_DIR, 64'hFFFF_FFFF); expect_at(56, S_STATE, 2);

        at(100); raw[5] = 1'b1;
        expect_at(101, S_IN, 64'h01);   expect_at(102, S_IN, 64'h21);
        expect_at(102, S_RISE, 0);      expect_at(103, S_RISE, 64'h20);
        expect_at(104, S_RISE, 0);

        at(110); raw[7] = 1'b1;
        expect_at(113, S_RISE, 64'h80); expect_at(114, S_FALL, 64'h80);
        expect_at(114, S_RISE, 0);      expect_at(115, S_RISE, 64'h80);
        expect_at(116, S_FALL, 64'h80); expect_at(117, S_FALL, 0);
        at(111); raw[7] = 1'b0;
        at(112); raw[7] = 1'b1;
        at(113); raw[7] = 1'b0;

        at(120); sw_res = 1'b1;
        at(121); sw_res = 1'b0;
        expect_at(127, S_STATE, 1);
        expect_at(128, S_STATE, 0); expect_at(128, S_IN, 0);
        expect_at(128, S_NRES, 0);  expect_at(128, S_DIR, 0);
        at(128); nres = 1'b0;

        at(130); nres = 1'b1;
        expect_at(130, S_STATE, 1); expect_at(145, S_STATE, 1); expect_at(145, S_NRES, 0);
        expect_at(146, S_STATE, 2); expect_at(146, S_NRES, 1);  expect_at(147, S_RISE, 0);

        at(160);
        @(negedge clk_cog);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
